// File: rtl/control_unit_pkg.sv
// Shared types and encodings for the multi-cycle control unit:
// sequencer states, instruction classes, opcodes and instruction field positions.
package cpu_pkg;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    LDI_WR = 4'd3,
    RD_A   = 4'd4,
    RD_B   = 4'd5,
    EXEC   = 4'd6,
    WB     = 4'd7,
    NEXT   = 4'd8,
    DONE   = 4'd9,
    HALTED = 4'd10
  } state_e;

  typedef enum logic [1:0] {
    CLS_NOP  = 2'd0,
    CLS_LDI  = 2'd1,
    CLS_ALU  = 2'd2,
    CLS_HALT = 2'd3
  } iclass_e;

  localparam logic [3:0] OP_LDI  = 4'b1000;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  localparam int CLS_MSB   = 15;
  localparam int CLS_LSB   = 12;
  localparam int ALUOP_MSB = 15;
  localparam int ALUOP_LSB = 13;
  localparam int RD_MSB    = 9;
  localparam int RD_LSB    = 8;
  localparam int RS1_MSB   = 5;
  localparam int RS1_LSB   = 4;
  localparam int RS2_MSB   = 1;
  localparam int RS2_LSB   = 0;
  localparam int IMM_MSB   = 7;
  localparam int IMM_LSB   = 0;

  // A clear top bit marks an ALU op regardless of the remaining class bits.
  function automatic iclass_e classify(input logic [3:0] op);
    if (op[3] == 1'b0) begin
      return CLS_ALU;
    end else if (op == OP_LDI) begin
      return CLS_LDI;
    end else if (op == OP_HALT) begin
      return CLS_HALT;
    end else begin
      return CLS_NOP;
    end
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Bus between the control unit and its datapath: instruction register,
// register file, ALU, plus start/status handshake.
interface control_unit_if #(
  parameter int PC_W   = 2,
  parameter int DATA_W = 8
);
  logic              start;
  logic [PC_W-1:0]   ir_pc;
  logic              ir_en;
  logic [15:0]       ir_data;
  logic [1:0]        reg_addr;
  logic              reg_rd;
  logic              reg_wr;
  logic [DATA_W-1:0] reg_wdata;
  logic [DATA_W-1:0] reg_rdata;
  logic [2:0]        alu_op;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_y;
  logic              busy;
  logic              done;
  logic              halted;

  modport master (
    input  start, ir_data, reg_rdata, alu_y,
    output ir_pc, ir_en, reg_addr, reg_rd, reg_wr, reg_wdata,
           alu_op, alu_a, alu_b, busy, done, halted
  );

  modport slave (
    output start, ir_data, reg_rdata, alu_y,
    input  ir_pc, ir_en, reg_addr, reg_rd, reg_wr, reg_wdata,
           alu_op, alu_a, alu_b, busy, done, halted
  );
endinterface

// File: rtl/control_unit_instr_decode.sv
// Combinational instruction decoder: splits a 16-bit word into class,
// register fields, immediate and ALU opcode.
module instr_decode
  import cpu_pkg::*;
(
  input  logic [15:0] ir_i,
  output iclass_e     cls_o,
  output logic [1:0]  rd_o,
  output logic [1:0]  rs1_o,
  output logic [1:0]  rs2_o,
  output logic [7:0]  imm_o,
  output logic [2:0]  alu_op_o
);
  logic unused_bits_s;

  always_comb begin
    cls_o    = classify(ir_i[CLS_MSB:CLS_LSB]);
    rd_o     = ir_i[RD_MSB:RD_LSB];
    rs1_o    = ir_i[RS1_MSB:RS1_LSB];
    rs2_o    = ir_i[RS2_MSB:RS2_LSB];
    imm_o    = ir_i[IMM_MSB:IMM_LSB];
    alu_op_o = ir_i[ALUOP_MSB:ALUOP_LSB];
  end

  assign unused_bits_s = &{1'b0, ir_i[11:10]};

endmodule

// File: rtl/control_unit.sv
// Fetch/decode/execute sequencer for the 8-bit datapath; strobes are
// registered from the next state so they line up with the state they belong to.
module control_unit
  import cpu_pkg::*;
#(
  parameter int PC_W     = 2,
  parameter int PROG_LEN = 4,
  parameter int DATA_W   = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  control_unit_if.master bus
);
  localparam logic [PC_W-1:0] LAST_PC = PC_W'(PROG_LEN - 1);
  localparam logic [PC_W-1:0] PC_ONE  = PC_W'(1);

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [15:0]       ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]        alu_op_q, alu_op_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [PC_W-1:0]   ir_pc_q, ir_pc_d;
  logic              ir_en_q, ir_en_d;
  logic [1:0]        reg_addr_q, reg_addr_d;
  logic              reg_rd_q, reg_rd_d, reg_wr_q, reg_wr_d;
  logic [DATA_W-1:0] reg_wdata_q, reg_wdata_d;
  logic              busy_q, busy_d, done_q, done_d, halted_q, halted_d;

  iclass_e           dec_cls;
  logic [1:0]        dec_rd, dec_rs1, dec_rs2;
  logic [7:0]        dec_imm;
  logic [2:0]        dec_alu_op;

  // The decoder sees the word being latched in DECODE so the next state can branch on it.
  assign ir_d = (state_q == DECODE) ? bus.ir_data : ir_q;

  instr_decode u_dec (
    .ir_i    (ir_d),
    .cls_o   (dec_cls),
    .rd_o    (dec_rd),
    .rs1_o   (dec_rs1),
    .rs2_o   (dec_rs2),
    .imm_o   (dec_imm),
    .alu_op_o(dec_alu_op)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    a_d      = a_q;
    b_d      = b_q;
    alu_op_d = alu_op_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    case (state_q)
      IDLE, HALTED: begin
        if (bus.start) begin
          pc_d    = '0;
          state_d = FETCH;
        end else begin
          state_d = state_q;
        end
      end
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (dec_cls)
          CLS_LDI:  state_d = LDI_WR;
          CLS_ALU:  state_d = RD_A;
          CLS_HALT: state_d = HALTED;
          default:  state_d = NEXT;
        endcase
      end
      LDI_WR: state_d = NEXT;
      RD_A:   state_d = RD_B;
      RD_B: begin
        a_d     = bus.reg_rdata;
        state_d = EXEC;
      end
      // ALU inputs are loaded here and then held until the next ALU instruction.
      EXEC: begin
        b_d      = bus.reg_rdata;
        alu_op_d = dec_alu_op;
        alu_a_d  = a_q;
        alu_b_d  = bus.reg_rdata;
        state_d  = WB;
      end
      WB:   state_d = NEXT;
      NEXT: begin
        if (pc_q == LAST_PC) begin
          state_d = DONE;
        end else begin
          pc_d    = pc_q + PC_ONE;
          state_d = FETCH;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ir_pc_d     = '0;
    ir_en_d     = 1'b0;
    reg_addr_d  = 2'b00;
    reg_rd_d    = 1'b0;
    reg_wr_d    = 1'b0;
    reg_wdata_d = '0;
    done_d      = 1'b0;
    halted_d    = 1'b0;
    busy_d      = !((state_d == IDLE) || (state_d == HALTED));
    case (state_d)
      FETCH, DECODE: begin
        ir_pc_d = pc_d;
        ir_en_d = 1'b1;
      end
      LDI_WR: begin
        reg_addr_d  = dec_rd;
        reg_wr_d    = 1'b1;
        reg_wdata_d = DATA_W'(dec_imm);
      end
      RD_A: begin
        reg_addr_d = dec_rs1;
        reg_rd_d   = 1'b1;
      end
      RD_B: begin
        reg_addr_d = dec_rs2;
        reg_rd_d   = 1'b1;
      end
      WB: begin
        reg_addr_d = dec_rd;
        reg_wr_d   = 1'b1;
      end
      DONE:    done_d   = 1'b1;
      HALTED:  halted_d = 1'b1;
      default: busy_d   = busy_d;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pc_q        <= '0;
      ir_q        <= 16'h0000;
      a_q         <= '0;
      b_q         <= '0;
      alu_op_q    <= 3'b000;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      ir_pc_q     <= '0;
      ir_en_q     <= 1'b0;
      reg_addr_q  <= 2'b00;
      reg_rd_q    <= 1'b0;
      reg_wr_q    <= 1'b0;
      reg_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      a_q         <= a_d;
      b_q         <= b_d;
      alu_op_q    <= alu_op_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      ir_pc_q     <= ir_pc_d;
      ir_en_q     <= ir_en_d;
      reg_addr_q  <= reg_addr_d;
      reg_rd_q    <= reg_rd_d;
      reg_wr_q    <= reg_wr_d;
      reg_wdata_q <= reg_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      halted_q    <= halted_d;
    end
  end

  assign bus.ir_pc     = ir_pc_q;
  assign bus.ir_en     = ir_en_q;
  assign bus.reg_addr  = reg_addr_q;
  assign bus.reg_rd    = reg_rd_q;
  assign bus.reg_wr    = reg_wr_q;
  // The ALU result only settles once WB presents its operands, so it bypasses the register.
  assign bus.reg_wdata = (state_q == WB) ? bus.alu_y : reg_wdata_q;
  assign bus.alu_op    = alu_op_q;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.halted    = halted_q;

endmodule
